// File: rtl/instruction_fetch_buffer_pkg.sv
// rtl/instruction_fetch_buffer_pkg.sv - shared types and constants for the instruction fetch buffer
package instruction_fetch_buffer_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int IMEM_READ_LATENCY = 1;
  localparam int INSTR_BYTES       = 4;

  function automatic logic [31:0] word_offset(input int idx);
    return 32'(idx * INSTR_BYTES);
  endfunction

endpackage

// File: rtl/instruction_fetch_buffer_if.sv
// rtl/instruction_fetch_buffer_if.sv - imem, redirect and issue-side signals of the fetch buffer
interface instruction_fetch_buffer_if #(
  parameter int FETCH_WIDTH = 8,
  parameter int ISSUE_WIDTH = 8,
  parameter int DEPTH       = 32
);
  localparam int DW = $clog2(ISSUE_WIDTH + 1);
  localparam int OW = $clog2(DEPTH + 1);

  logic [31:0]                        imem_addr;
  logic [FETCH_WIDTH-1:0][31:0]       imem_data;
  logic                               redirect_valid;
  logic [31:0]                        redirect_pc;
  logic [ISSUE_WIDTH-1:0]             out_valid;
  logic [ISSUE_WIDTH-1:0][31:0]       out_instr;
  logic [ISSUE_WIDTH-1:0][31:0]       out_pc;
  logic [DW-1:0]                      deq_count;
  logic [OW-1:0]                      occupancy;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    output out_instr,
    output out_pc,
    input  deq_count,
    output occupancy
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output deq_count,
    input  occupancy
  );

endinterface

// File: rtl/instruction_fetch_buffer_ring.sv
// rtl/instruction_fetch_buffer_ring.sv - circular {pc, instr} store with multi-push, clamped multi-pop and flush
module fetch_ring_buffer
  import instruction_fetch_buffer_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int FETCH_WIDTH = 8,
  parameter int ISSUE_WIDTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int OW = $clog2(DEPTH + 1),
  localparam int DW = $clog2(ISSUE_WIDTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [31:0]                  i_push_pc,
  input  logic [FETCH_WIDTH-1:0][31:0] i_push_data,
  input  logic [DW-1:0]                i_pop_count,
  output logic [ISSUE_WIDTH-1:0]       o_valid,
  output logic [ISSUE_WIDTH-1:0][31:0] o_instr,
  output logic [ISSUE_WIDTH-1:0][31:0] o_pc,
  output logic [OW-1:0]                o_occupancy
);

  fetch_entry_t   r_mem [DEPTH];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [OW-1:0]  r_occ;

  logic [OW-1:0]  w_pop;
  logic [OW-1:0]  w_eff;
  logic [OW-1:0]  w_push_n;

  // Over-asking the queue is a protocol error; pop only what is held.
  always_comb begin
    w_pop    = OW'(i_pop_count);
    w_eff    = (w_pop > r_occ) ? r_occ : w_pop;
    w_push_n = i_push ? OW'(FETCH_WIDTH) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      r_head <= r_head + PW'(w_eff);
      r_occ  <= r_occ - w_eff + w_push_n;
      if (i_push) begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
          r_mem[r_tail + PW'(k)] <= '{pc: i_push_pc + word_offset(k), instr: i_push_data[k]};
        end
        r_tail <= r_tail + PW'(FETCH_WIDTH);
      end
    end
  end

  always_comb begin
    o_valid     = '0;
    o_instr     = '0;
    o_pc        = '0;
    o_occupancy = r_occ;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      o_valid[k] = (r_occ > OW'(k));
      o_instr[k] = r_mem[r_head + PW'(k)].instr;
      o_pc[k]    = r_mem[r_head + PW'(k)].pc;
    end
  end

endmodule

// File: rtl/instruction_fetch_buffer.sv
// rtl/instruction_fetch_buffer.sv - fetch PC sequencing, redirect flush and queueing of imem groups
// Optional: FETCH_BUF_PERF_EN adds perf_stall_cycles / perf_flush_count saturating counters.
module instruction_fetch_buffer
  import instruction_fetch_buffer_pkg::*;
#(
  parameter int          FETCH_WIDTH = 8,
  parameter int          ISSUE_WIDTH = 8,
  parameter int          DEPTH       = 32,
  parameter logic [31:0] START_PC    = 32'h0000_3000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instruction_fetch_buffer_if.master bus
`ifdef FETCH_BUF_PERF_EN
  ,
  output logic [31:0]                perf_stall_cycles,
  output logic [31:0]                perf_flush_count
`endif
);

  localparam int OW = $clog2(DEPTH + 1);

  logic [31:0]   r_fetch_pc;
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;

  logic [OW-1:0] w_occ;
  logic [31:0]   w_addr;
  logic          w_room;
  logic          w_issue;
  logic          w_push;

  // Room is reserved for the group still on its way back from imem.
  always_comb begin
    w_room  = (32'(w_occ)
               + (r_inflight ? 32'(IMEM_READ_LATENCY * FETCH_WIDTH) : 32'd0)
               + 32'(FETCH_WIDTH)) <= 32'(DEPTH);
    w_issue = bus.redirect_valid | w_room;
    w_addr  = bus.redirect_valid ? bus.redirect_pc : r_fetch_pc;
    w_push  = r_inflight & ~bus.redirect_valid;
  end

  assign bus.imem_addr = w_addr;
  assign bus.occupancy = w_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= START_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= START_PC;
    end else if (w_issue) begin
      r_inflight    <= 1'b1;
      r_inflight_pc <= w_addr;
      r_fetch_pc    <= w_addr + word_offset(FETCH_WIDTH);
    end else begin
      r_inflight    <= 1'b0;
    end
  end

  fetch_ring_buffer #(
    .DEPTH       (DEPTH),
    .FETCH_WIDTH (FETCH_WIDTH),
    .ISSUE_WIDTH (ISSUE_WIDTH)
  ) u_ring (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (bus.redirect_valid),
    .i_push      (w_push),
    .i_push_pc   (r_inflight_pc),
    .i_push_data (bus.imem_data),
    .i_pop_count (bus.deq_count),
    .o_valid     (bus.out_valid),
    .o_instr     (bus.out_instr),
    .o_pc        (bus.out_pc),
    .o_occupancy (w_occ)
  );

`ifdef FETCH_BUF_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!w_issue && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (bus.redirect_valid && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = r_stall_cycles;
  assign perf_flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// tb/tb_instruction_fetch_buffer.sv - bench for instruction_fetch_buffer against a queue-based model
module tb_instruction_fetch_buffer;

  localparam int FW    = 8;
  localparam int IW    = 8;
  localparam int DEPTH = 32;
  localparam logic [31:0] START = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instruction_fetch_buffer_if #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH)) bus ();

`ifdef FETCH_BUF_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
`endif

  instruction_fetch_buffer #(
    .FETCH_WIDTH (FW),
    .ISSUE_WIDTH (IW),
    .DEPTH       (DEPTH),
    .START_PC    (START)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_BUF_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  // Instruction memory: one-cycle read latency.
  logic [31:0] mem_addr_q = 32'h0;
  always @(posedge clk) mem_addr_q <= bus.imem_addr;
  always_comb begin
    bus.imem_data = '0;
    for (int k = 0; k < FW; k++) bus.imem_data[k] = mem_word(mem_addr_q + 32'(4 * k));
  end

  int n_vec = 0;
  int n_err = 0;

  ent_t        q[$];
  logic [31:0] m_fetch_pc;
  bit          m_inflight;
  logic [31:0] m_ipc;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fetch_pc = START;
    m_inflight = 0;
    m_ipc      = START;
  endtask

  task automatic model_clock(input bit rv, input logic [31:0] rpc, input int deq);
    int          occ;
    int          eff;
    bit          issue;
    logic [31:0] addr;
    occ  = q.size();
    addr = rv ? rpc : m_fetch_pc;
    if (rv) begin
      q.delete();
      issue = 1;
    end else begin
      issue = (occ + (m_inflight ? FW : 0) + FW) <= DEPTH;
      eff   = (deq < occ) ? deq : occ;
      repeat (eff) void'(q.pop_front());
      if (m_inflight)
        for (int k = 0; k < FW; k++)
          q.push_back('{pc: m_ipc + 32'(4 * k), instr: mem_word(m_ipc + 32'(4 * k))});
    end
    if (issue) begin
      m_inflight = 1;
      m_ipc      = addr;
      m_fetch_pc = addr + 32'(4 * FW);
    end else begin
      m_inflight = 0;
    end
  endtask

  task automatic check_outputs();
    logic [IW-1:0]       ev;
    logic [IW-1:0][31:0] opc, epc, oin, ein;
    ev = '0; opc = '0; epc = '0; oin = '0; ein = '0;
    for (int k = 0; k < IW; k++) begin
      if (k < q.size()) begin
        ev[k]  = 1'b1;
        opc[k] = bus.out_pc[k];
        oin[k] = bus.out_instr[k];
        epc[k] = q[k].pc;
        ein[k] = q[k].instr;
      end
    end
    chk("occupancy", 256'(bus.occupancy), 256'(q.size()));
    chk("out_valid", 256'(bus.out_valid), 256'(ev));
    chk("out_pc", 256'(opc), 256'(epc));
    chk("out_instr", 256'(oin), 256'(ein));
  endtask

  // Called #1 after a rising edge; returns #1 after the next one.
  task automatic step(input bit rv, input logic [31:0] rpc, input int deq);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.deq_count      = 4'(deq);
    #2;
    chk("imem_addr", 256'(bus.imem_addr), 256'(rv ? rpc : m_fetch_pc));
    @(posedge clk);
    model_clock(rv, rpc, deq);
    #1;
    check_outputs();
  endtask

  logic [31:0] exp_pc0;
  logic [31:0] rnd_pc;

  initial begin
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.deq_count      = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_occupancy", 256'(bus.occupancy), 256'(0));
    chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_out_pc", 256'(bus.out_pc), 256'(0));
    chk("rst_out_instr", 256'(bus.out_instr), 256'(0));
    chk("rst_imem_addr", 256'(bus.imem_addr), 256'(START));
    rst_n = 1'b1;

    // Fill from reset with nothing consumed.
    for (int i = 0; i < 8; i++) step(0, 0, 0);
    chk("fill_occupancy", 256'(bus.occupancy), 256'(32));
    chk("fill_out_pc0", 256'(bus.out_pc[0]), 256'(32'h3000));
    chk("fill_out_valid", 256'(bus.out_valid), 256'(8'hFF));

    // Full-rate consumption, through pointer wrap.
    exp_pc0 = 32'h3000;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 8);
      exp_pc0 = exp_pc0 + 32'h20;
      chk("steady_pc0", 256'(bus.out_pc[0]), 256'(exp_pc0));
    end

    // Redirect while a group is in flight.
    step(0, 0, 0);
    step(1, 32'h3100, 0);
    chk("redir_occupancy", 256'(bus.occupancy), 256'(0));
    chk("redir_out_valid", 256'(bus.out_valid), 256'(0));
    step(0, 0, 8);
    chk("clamp_push_occupancy", 256'(bus.occupancy), 256'(8));
    chk("redir_out_pc0", 256'(bus.out_pc[0]), 256'(32'h3100));
    chk("redir_out_pc7", 256'(bus.out_pc[7]), 256'(32'h311C));
    step(0, 0, 3);
    chk("deq3_out_pc0", 256'(bus.out_pc[0]), 256'(32'h310C));

    // Back-to-back redirects: only the later one survives.
    step(1, 32'h4000, 0);
    step(1, 32'h5000, 5);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("b2b_out_pc0", 256'(bus.out_pc[0]), 256'(32'h5000));

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rnd_pc = {14'h0, 16'($urandom), 2'b00};
      step($urandom_range(0, 99) < 4, rnd_pc,
           (i < 750) ? $urandom_range(0, 4) : $urandom_range(0, 8));
    end

    // Asynchronous reset with a group in flight.
    step(1, 32'h7700, 0);
    bus.redirect_valid = 1'b0;
    bus.deq_count      = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_occupancy", 256'(bus.occupancy), 256'(0));
    chk("arst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("arst_out_pc", 256'(bus.out_pc), 256'(0));
    chk("arst_imem_addr", 256'(bus.imem_addr), 256'(START));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) step(0, 0, $urandom_range(0, 8));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
